seq_shift_add_multiplier: RTL and testbench

SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_sign_unit.sv | 16 +
 rtl/seq_shift_add_multiplier.sv | 111 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and default widths for the sequential multiplier
package mult_pkg;

    localparam int DEFAULT_M = 8;
    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Counter width for N iterations, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_sign_unit.sv
// rtl/mult_sign_unit.sv - combinational conditional two's-complement negate
module mult_sign_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         en,
    output logic [W-1:0] y
);

    // Absolute value at load (en = operand sign) and signed writeback (en = result sign).
    // The most negative input maps to 2^(W-1), which is exact when read as unsigned.
    always_comb begin
        y = en ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - one-bit-per-cycle shift-and-add multiplier
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int M          = DEFAULT_M,
    parameter int N          = DEFAULT_N,
    parameter int EARLY_EXIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [M+N-1:0] product
);

    localparam int CW = cnt_width(N);
    localparam int PW = M + N;

    mult_state_t   state;
    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [N-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic          neg;

    logic [M-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [PW-1:0] acc_next;
    logic [PW-1:0] product_wb;
    logic          last_step;

    mult_sign_unit #(.W(M)) u_abs_a (
        .x  (a),
        .en (signed_mode & a[M-1]),
        .y  (a_mag)
    );

    mult_sign_unit #(.W(N)) u_abs_b (
        .x  (b),
        .en (signed_mode & b[N-1]),
        .y  (b_mag)
    );

    mult_sign_unit #(.W(PW)) u_neg_res (
        .x  (acc_next),
        .en (neg),
        .y  (product_wb)
    );

    // Partial-product sum for this cycle and the termination test
    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        last_step = (cnt == CW'(N - 1)) ||
                    ((EARLY_EXIT != 0) && ((mplier >> 1) == '0));
    end

    // Control FSM with datapath registers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        acc    <= '0;
                        cnt    <= '0;
                        mcand  <= PW'(a_mag);
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[M-1] ^ b[N-1]);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= product_wb;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - randomized self-checking bench for the multiplier
module tb_seq_shift_add_multiplier;

    localparam int M = 8;
    localparam int N = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [1:0]  sm_v;
    logic [M-1:0] a_v [2];
    logic [N-1:0] b_v [2];
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [M+N-1:0] prod_v [2];

    int vectors;
    int miscompares;

    seq_shift_add_multiplier #(.M(M), .N(N), .EARLY_EXIT(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_v[0]),
        .signed_mode (sm_v[0]),
        .a           (a_v[0]),
        .b           (b_v[0]),
        .busy        (busy_v[0]),
        .done        (done_v[0]),
        .product     (prod_v[0])
    );

    seq_shift_add_multiplier #(.M(M), .N(N), .EARLY_EXIT(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_v[1]),
        .signed_mode (sm_v[1]),
        .a           (a_v[1]),
        .b           (b_v[1]),
        .busy        (busy_v[1]),
        .done        (done_v[1]),
        .product     (prod_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: operand values as plain integers, product truncated to M+N bits
    function automatic longint ref_val(input bit sm, input longint raw, input int w);
        if (sm && raw >= (longint'(1) << (w - 1)))
            return raw - (longint'(1) << w);
        return raw;
    endfunction

    function automatic longint ref_prod(input bit sm, input longint a, input longint b);
        longint p;
        p = ref_val(sm, a, M) * ref_val(sm, b, N);
        return p & ((longint'(1) << (M + N)) - 1);
    endfunction

    // Edges from accept to done: N+1 normally, else one per significant bit of |b| plus one
    function automatic int ref_lat(input bit ee, input bit sm, input longint b);
        longint mag;
        int k;
        if (!ee) return N + 1;
        mag = ref_val(sm, b, N);
        if (mag < 0) mag = -mag;
        k = 0;
        while ((mag >> k) != 0) k++;
        if (k < 1) k = 1;
        return k + 1;
    endfunction

    task automatic do_op(input int inst, input bit sm, input longint a, input longint b);
        int e;
        int lat;
        @(negedge clk);
        sm_v[inst]    = sm;
        a_v[inst]     = a[M-1:0];
        b_v[inst]     = b[N-1:0];
        start_v[inst] = 1'b1;
        @(posedge clk);
        e = 1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        chk("busy_in_run", longint'(busy_v[inst]), 1);
        while (done_v[inst] !== 1'b1 && e < 64) begin
            @(negedge clk);
            e++;
        end
        lat = ref_lat(inst == 1, sm, b);
        chk($sformatf("latency i%0d sm%0d a%0d b%0d", inst, sm, a, b), e, lat);
        chk($sformatf("product i%0d sm%0d a%0d b%0d", inst, sm, a, b),
            longint'(prod_v[inst]), ref_prod(sm, a, b));
        @(negedge clk);
        chk("done_one_cycle", longint'(done_v[inst]), 0);
    endtask

    initial begin
        int e;
        int d1;
        int d2;
        bit saw_done;
        longint p1;
        longint p2;
        longint ra;
        longint rb;
        bit rsm;

        vectors     = 0;
        miscompares = 0;
        start_v     = '0;
        sm_v        = '0;
        a_v[0] = '0; a_v[1] = '0;
        b_v[0] = '0; b_v[1] = '0;
        rst_n       = 1'b0;

        #23;
        chk("reset_busy", longint'(busy_v), 0);
        chk("reset_done", longint'(done_v), 0);
        chk("reset_product", longint'(prod_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases: first start right after reset release
        do_op(0, 1'b0, 255, 255);
        do_op(0, 1'b1, 128, 128);
        do_op(0, 1'b1, 128, 127);
        do_op(1, 1'b0, 7, 3);
        do_op(1, 1'b0, 7, 0);
        do_op(1, 1'b1, 0, 128);
        do_op(1, 1'b1, 128, 255);
        do_op(0, 1'b1, 0, 200);

        // Product holds through idle cycles
        repeat (5) @(negedge clk);
        chk("product_hold", longint'(prod_v[0]), 0);
        do_op(0, 1'b1, 3, 253);
        repeat (4) @(negedge clk);
        chk("product_hold_neg", longint'(prod_v[0]), ref_prod(1'b1, 3, 253));

        // Back-to-back: start held through RUN and DONE
        @(negedge clk);
        sm_v[0] = 1'b0; a_v[0] = 8'd5; b_v[0] = 8'd6; start_v[0] = 1'b1;
        @(posedge clk);
        e = 1; d1 = -1; d2 = -1; p1 = -1; p2 = -1;
        @(negedge clk);
        a_v[0] = 8'd10; b_v[0] = 8'd20;
        while (d2 < 0 && e < 64) begin
            if (done_v[0] === 1'b1) begin
                if (d1 < 0) begin
                    d1 = e; p1 = longint'(prod_v[0]);
                end else begin
                    d2 = e; p2 = longint'(prod_v[0]);
                end
            end
            if (d1 >= 0 && e > d1) start_v[0] = 1'b0;
            @(negedge clk);
            e++;
        end
        start_v[0] = 1'b0;
        chk("b2b_first_latency", d1, N + 1);
        chk("b2b_separation", d2 - d1, N + 1);
        chk("b2b_product1", p1, 30);
        chk("b2b_product2", p2, 200);
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN
        @(negedge clk);
        sm_v[0] = 1'b0; a_v[0] = 8'd255; b_v[0] = 8'd255; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", longint'(busy_v[0]), 0);
        chk("midrun_rst_done", longint'(done_v[0]), 0);
        chk("midrun_rst_product", longint'(prod_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) saw_done = 1'b1;
        end
        chk("no_done_after_reset", longint'(saw_done), 0);
        do_op(0, 1'b1, 200, 77);

        // Randomized sweep on both instances
        for (int i = 0; i < 3000; i++) begin
            rsm = 1'($urandom_range(0, 1));
            ra  = longint'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = longint'($urandom_range(0, 3));
                1:       rb = longint'($urandom_range(0, 15));
                default: rb = longint'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 15) == 0) ra = 128;
            do_op(i % 2, rsm, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
